// File: rtl/sram_rr_arbiter_if.sv
// Bundles for the shared scratchpad arbiter: requester-side bus (master = requesters)
// and RAM-side pins (master = arbiter).
interface sram_rr_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10
);
  logic [NUM_REQ-1:0]                 Req_SI;
  logic [NUM_REQ-1:0]                 WrEn_SI;
  logic [NUM_REQ-1:0][7:0]            BEn_SI;
  logic [NUM_REQ-1:0][63:0]           WrData_DI;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] Addr_DI;
  logic [NUM_REQ-1:0]                 Gnt_SO;
  logic [NUM_REQ-1:0]                 RVld_SO;
  logic [63:0]                        RData_DO;

  modport master (
    output Req_SI, WrEn_SI, BEn_SI, WrData_DI, Addr_DI,
    input  Gnt_SO, RVld_SO, RData_DO
  );

  modport slave (
    input  Req_SI, WrEn_SI, BEn_SI, WrData_DI, Addr_DI,
    output Gnt_SO, RVld_SO, RData_DO
  );
endinterface

interface sram_rr_ram_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  RamCSel_SO;
  logic                  RamWrEn_SO;
  logic [7:0]            RamBEn_SO;
  logic [63:0]           RamWrData_DO;
  logic [ADDR_WIDTH-1:0] RamAddr_DO;
  logic [63:0]           RamRdData_DI;

  modport master (
    output RamCSel_SO, RamWrEn_SO, RamBEn_SO, RamWrData_DO, RamAddr_DO,
    input  RamRdData_DI
  );

  modport slave (
    input  RamCSel_SO, RamWrEn_SO, RamBEn_SO, RamWrData_DO, RamAddr_DO,
    output RamRdData_DI
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one 64-bit byte-enable SRAM between NUM_REQ requesters,
// steering read data back to the requester that issued it.
module sram_rr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REGS   = 0
) (
  input  logic               Clk_CI,
  input  logic               Rst_RI,
  sram_rr_arbiter_if.slave   bus,
  sram_rr_ram_if.master      ram
);
  localparam int RD_LAT = (OUT_REGS > 0) ? 2 : 1;
  localparam int IDW    = $clog2(NUM_REQ);

  logic [IDW-1:0]             ptr_q, ptr_d;
  logic [IDW-1:0]             win, cand;
  logic                       found;
  logic [NUM_REQ-1:0]         gnt, rvld;
  logic [RD_LAT-1:0]          vld_q, vld_d;
  logic [RD_LAT-1:0][IDW-1:0] id_q, id_d;

  // Scan from the priority pointer; the first requester found wins.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.Req_SI[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (Rst_RI) begin
      found = 1'b0;
    end
    gnt   = found ? (NUM_REQ'(1) << win) : '0;
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    ram.RamCSel_SO   = 1'b0;
    ram.RamWrEn_SO   = 1'b0;
    ram.RamBEn_SO    = '0;
    ram.RamWrData_DO = '0;
    ram.RamAddr_DO   = '0;
    if (found) begin
      ram.RamCSel_SO   = 1'b1;
      ram.RamWrEn_SO   = bus.WrEn_SI[win];
      ram.RamBEn_SO    = bus.BEn_SI[win];
      ram.RamWrData_DO = bus.WrData_DI[win];
      ram.RamAddr_DO   = bus.Addr_DI[win];
    end
  end

  // Read-return pipeline matches the RAM latency so ids line up with RdData.
  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = found & ~bus.WrEn_SI[win];
    id_d[0]  = win;
    for (int s = 1; s < RD_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      id_d[s]  = id_q[s-1];
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      ptr_q <= '0;
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  always_comb begin
    rvld = '0;
    if (vld_q[RD_LAT-1] && !Rst_RI) begin
      rvld[id_q[RD_LAT-1]] = 1'b1;
    end
    bus.Gnt_SO   = gnt;
    bus.RVld_SO  = rvld;
    bus.RData_DO = (|rvld) ? ram.RamRdData_DI : '0;
  end
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: a 2-requester/OUT_REGS=0 instance and a
// 4-requester/OUT_REGS=1 instance, each attached to a behavioural RAM.
module tb_sram_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_rr_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(10)) busA ();
  sram_rr_ram_if     #(.ADDR_WIDTH(10))              ramA ();
  sram_rr_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(10)) busB ();
  sram_rr_ram_if     #(.ADDR_WIDTH(10))              ramB ();

  sram_rr_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(10), .OUT_REGS(0)) dutA (
    .Clk_CI(clk), .Rst_RI(rst), .bus(busA), .ram(ramA)
  );
  sram_rr_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(10), .OUT_REGS(1)) dutB (
    .Clk_CI(clk), .Rst_RI(rst), .bus(busB), .ram(ramB)
  );

  function automatic logic [63:0] initWord(input logic [9:0] a);
    if (a == 10'd5) return 64'h1122334455667788;
    return {32'hCAFE0000 | {22'h0, a}, 32'h0BAD0000 | {22'h0, a}};
  endfunction

  function automatic logic [63:0] mergeBytes(input logic [63:0] old, input logic [7:0] be,
                                             input logic [63:0] wd);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // RAM model A: one-cycle read latency, unwritten words read as initWord.
  logic [63:0] memA [1024];
  bit          wrA  [1024];
  logic [63:0] rdA;

  function automatic logic [63:0] readA(input logic [9:0] a);
    return wrA[a] ? memA[a] : initWord(a);
  endfunction

  always @(posedge clk) begin
    if (ramA.RamCSel_SO) begin
      if (ramA.RamWrEn_SO) begin
        memA[ramA.RamAddr_DO] <= mergeBytes(readA(ramA.RamAddr_DO), ramA.RamBEn_SO, ramA.RamWrData_DO);
        wrA[ramA.RamAddr_DO]  <= 1'b1;
      end else begin
        rdA <= readA(ramA.RamAddr_DO);
      end
    end
  end
  assign ramA.RamRdData_DI = rdA;

  // RAM model B: read-only contents, extra output register.
  logic [63:0] rdB1, rdB2;
  always @(posedge clk) begin
    if (ramB.RamCSel_SO && !ramB.RamWrEn_SO) rdB1 <= initWord(ramB.RamAddr_DO);
    rdB2 <= rdB1;
  end
  assign ramB.RamRdData_DI = rdB2;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wren;
    logic [7:0]  ben;
    logic [63:0] wd;
    logic [9:0]  a0;
    logic [9:0]  a1;
    logic [1:0]  gnt;
    logic [9:0]  ea;
  } vec_t;

  typedef struct {
    int          id;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        expQ[$];
  logic [63:0] shA [1024];
  logic [9:0]  addrB [4];
  vec_t        vecs [15];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkScoreboard(input logic [3:0] rvld, input logic [63:0] rdata);
    exp_t e;
    if (rvld != 4'b0) begin
      if (expQ.size() == 0) begin
        chk("rvld_unexpected", {60'b0, rvld}, 64'b0);
      end else begin
        e = expQ.pop_front();
        chk("rvld_id", {60'b0, rvld}, 64'(4'b1 << e.id));
        chk("rdata", rdata, e.data);
        chk("rvld_cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("rdata_idle", rdata, 64'b0);
      if (expQ.size() != 0 && expQ[0].due <= cyc) begin
        e = expQ.pop_front();
        chk("rvld_missing", {60'b0, rvld}, 64'(4'b1 << e.id));
      end
    end
  endtask

  task automatic applyStimulus(input bit isB, input logic [3:0] req, input logic [3:0] wren,
                               input logic [7:0] ben, input logic [63:0] wd,
                               input logic [9:0] a0, input logic [9:0] a1);
    if (isB) begin
      busA.Req_SI  = '0;
      busB.Req_SI  = req;
      busB.WrEn_SI = '0;
      for (int i = 0; i < 4; i++) begin
        busB.BEn_SI[i]    = '0;
        busB.WrData_DI[i] = '0;
        busB.Addr_DI[i]   = addrB[i];
      end
    end else begin
      busB.Req_SI       = '0;
      busA.Req_SI       = req[1:0];
      busA.WrEn_SI      = wren[1:0];
      busA.BEn_SI[0]    = ben;
      busA.BEn_SI[1]    = ben;
      busA.WrData_DI[0] = wd;
      busA.WrData_DI[1] = wd;
      busA.Addr_DI[0]   = a0;
      busA.Addr_DI[1]   = a1;
    end
  endtask

  task automatic checkOutput(input bit isB, input logic [3:0] eg, input logic [9:0] ea,
                             input logic ew, input logic [7:0] eb, input logic [63:0] ewd);
    logic [3:0]  g, v;
    logic        cs, wr;
    logic [7:0]  be;
    logic [63:0] wd, rd;
    logic [9:0]  ad;
    int          id;
    exp_t        e;
    if (isB) begin
      g = busB.Gnt_SO; v = busB.RVld_SO; rd = busB.RData_DO;
      cs = ramB.RamCSel_SO; wr = ramB.RamWrEn_SO; be = ramB.RamBEn_SO;
      wd = ramB.RamWrData_DO; ad = ramB.RamAddr_DO;
    end else begin
      g = {2'b0, busA.Gnt_SO}; v = {2'b0, busA.RVld_SO}; rd = busA.RData_DO;
      cs = ramA.RamCSel_SO; wr = ramA.RamWrEn_SO; be = ramA.RamBEn_SO;
      wd = ramA.RamWrData_DO; ad = ramA.RamAddr_DO;
    end
    chk("gnt", {60'b0, g}, {60'b0, eg});
    chk("ram_csel", {63'b0, cs}, {63'b0, |eg});
    chk("ram_addr", {54'b0, ad}, (eg != 0) ? {54'b0, ea} : 64'b0);
    chk("ram_wren", {63'b0, wr}, (eg != 0) ? {63'b0, ew} : 64'b0);
    chk("ram_ben", {56'b0, be}, (eg != 0) ? {56'b0, eb} : 64'b0);
    chk("ram_wdata", wd, (eg != 0) ? ewd : 64'b0);
    checkScoreboard(v, rd);
    if (eg != 0) begin
      id = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) id = i;
      if (!ew) begin
        e.id   = id;
        e.data = isB ? initWord(ea) : shA[ea];
        e.due  = cyc + (isB ? 2 : 1);
        expQ.push_back(e);
      end else if (!isB) begin
        shA[ea] = mergeBytes(shA[ea], eb, ewd);
      end
    end
  endtask

  task automatic runCycle(input bit isB, input logic [3:0] req, input logic [3:0] wren,
                          input logic [7:0] ben, input logic [63:0] wd,
                          input logic [9:0] a0, input logic [9:0] a1,
                          input logic [3:0] eg, input logic [9:0] ea);
    applyStimulus(isB, req, wren, ben, wd, a0, a1);
    @(negedge clk);
    checkOutput(isB, eg, ea, |(eg & wren), isB ? 8'h00 : ben, isB ? 64'h0 : wd);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idleB(input int n);
    for (int i = 0; i < n; i++) runCycle(1'b1, 4'b0, 4'b0, 8'h0, 64'h0, 10'd0, 10'd0, 4'b0, 10'd0);
  endtask

  // One-cycle reset pulse with every requester asserting; nothing may leak out.
  task automatic doReset();
    rst = 1'b1;
    busA.Req_SI = '1;
    busB.Req_SI = '1;
    expQ.delete();
    @(negedge clk);
    chk("rst_gntA", {62'b0, busA.Gnt_SO}, 64'b0);
    chk("rst_gntB", {60'b0, busB.Gnt_SO}, 64'b0);
    chk("rst_cselA", {63'b0, ramA.RamCSel_SO}, 64'b0);
    chk("rst_cselB", {63'b0, ramB.RamCSel_SO}, 64'b0);
    chk("rst_addrA", {54'b0, ramA.RamAddr_DO}, 64'b0);
    chk("rst_rvldA", {62'b0, busA.RVld_SO}, 64'b0);
    chk("rst_rvldB", {60'b0, busB.RVld_SO}, 64'b0);
    chk("rst_rdataB", busB.RData_DO, 64'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    busA.Req_SI = '0;
    busB.Req_SI = '0;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] reqs;
    int         order [8];
    rst = 1'b1;
    addrB = '{10'd5, 10'd9, 10'd12, 10'd3};
    for (int i = 0; i < 1024; i++) shA[i] = initWord(10'(i));
    applyStimulus(1'b1, 4'b0, 4'b0, 8'h0, 64'h0, 10'd0, 10'd0);
    applyStimulus(1'b0, 4'b0, 4'b0, 8'h0, 64'h0, 10'd0, 10'd0);

    //          req    wren   ben    wdata                   a0     a1     gnt    ea
    vecs[0]  = '{2'b01, 2'b00, 8'h00, 64'h0,                  10'd5, 10'd0, 2'b01, 10'd5};
    vecs[1]  = '{2'b00, 2'b00, 8'h00, 64'h0,                  10'd0, 10'd0, 2'b00, 10'd0};
    vecs[2]  = '{2'b10, 2'b10, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, 10'd0, 10'd5, 2'b10, 10'd5};
    vecs[3]  = '{2'b10, 2'b00, 8'h00, 64'h0,                  10'd0, 10'd5, 2'b10, 10'd5};
    vecs[4]  = '{2'b00, 2'b00, 8'h00, 64'h0,                  10'd0, 10'd0, 2'b00, 10'd0};
    vecs[5]  = '{2'b01, 2'b01, 8'h00, 64'h0123_4567_89AB_CDEF, 10'd5, 10'd0, 2'b01, 10'd5};
    vecs[6]  = '{2'b11, 2'b00, 8'h00, 64'h0,                  10'd5, 10'd5, 2'b10, 10'd5};
    vecs[7]  = '{2'b01, 2'b00, 8'h00, 64'h0,                  10'd5, 10'd5, 2'b01, 10'd5};
    vecs[8]  = '{2'b01, 2'b00, 8'h00, 64'h0,                  10'd7, 10'd0, 2'b01, 10'd7};
    vecs[9]  = '{2'b10, 2'b10, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 10'd0, 10'd7, 2'b10, 10'd7};
    vecs[10] = '{2'b01, 2'b00, 8'h00, 64'h0,                  10'd7, 10'd0, 2'b01, 10'd7};
    vecs[11] = '{2'b11, 2'b11, 8'h3C, 64'h1111_2222_3333_4444, 10'd9, 10'd7, 2'b10, 10'd7};
    vecs[12] = '{2'b01, 2'b01, 8'h3C, 64'h1111_2222_3333_4444, 10'd9, 10'd7, 2'b01, 10'd9};
    vecs[13] = '{2'b01, 2'b00, 8'h00, 64'h0,                  10'd9, 10'd0, 2'b01, 10'd9};
    vecs[14] = '{2'b00, 2'b00, 8'h00, 64'h0,                  10'd0, 10'd0, 2'b00, 10'd0};

    doReset();
    $display("[TB] table vectors on 2-requester instance");
    foreach (vecs[i]) begin
      runCycle(1'b0, {2'b0, vecs[i].req}, {2'b0, vecs[i].wren}, vecs[i].ben, vecs[i].wd,
               vecs[i].a0, vecs[i].a1, {2'b0, vecs[i].gnt}, vecs[i].ea);
    end

    $display("[TB] contention after reset");
    doReset();
    for (int k = 0; k < 6; k++) begin
      runCycle(1'b0, 4'b0011, 4'b0, 8'h0, 64'h0, 10'd5, 10'd7,
               (k % 2 == 0) ? 4'b0001 : 4'b0010, (k % 2 == 0) ? 10'd5 : 10'd7);
    end
    runCycle(1'b0, 4'b0, 4'b0, 8'h0, 64'h0, 10'd0, 10'd0, 4'b0, 10'd0);
    runCycle(1'b0, 4'b0, 4'b0, 8'h0, 64'h0, 10'd0, 10'd0, 4'b0, 10'd0);

    $display("[TB] two-cycle latency on 4-requester instance");
    doReset();
    idleB(3);
    runCycle(1'b1, 4'b0010, 4'b0, 8'h0, 64'h0, 10'd0, 10'd0, 4'b0010, addrB[1]);
    runCycle(1'b1, 4'b1000, 4'b0, 8'h0, 64'h0, 10'd0, 10'd0, 4'b1000, addrB[3]);
    idleB(2);

    $display("[TB] fairness with one requester leaving");
    reqs  = 4'b1111;
    order = '{0, 1, 2, 3, 0, 1, 3, 0};
    for (int k = 0; k < 8; k++) begin
      runCycle(1'b1, reqs, 4'b0, 8'h0, 64'h0, 10'd0, 10'd0, 4'b1 << order[k], addrB[order[k]]);
      if (order[k] == 2) reqs[2] = 1'b0;
    end
    idleB(3);

    $display("[TB] reset with a read in flight");
    runCycle(1'b1, 4'b0001, 4'b0, 8'h0, 64'h0, 10'd0, 10'd0, 4'b0001, addrB[0]);
    doReset();
    runCycle(1'b1, 4'b0011, 4'b0, 8'h0, 64'h0, 10'd0, 10'd0, 4'b0001, addrB[0]);
    idleB(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
